// File: rtl/meter_pkg.sv
// Shared constants and BCD arithmetic helpers for the parking-meter time path.
package meter_pkg;

    localparam int unsigned DIG_W = 4;
    localparam int unsigned N_DIG = 4;
    localparam int unsigned BCD_W = DIG_W * N_DIG;

    localparam logic [BCD_W-1:0] ADD50          = 16'h0050;
    localparam logic [BCD_W-1:0] ADD150         = 16'h0150;
    localparam logic [BCD_W-1:0] ADD200         = 16'h0200;
    localparam logic [BCD_W-1:0] ADD500         = 16'h0500;
    localparam logic [BCD_W-1:0] PRE15          = 16'h0015;
    localparam logic [BCD_W-1:0] PRE185         = 16'h0185;
    localparam logic [BCD_W-1:0] BCD_MAX        = 16'h9999;
    localparam logic [BCD_W-1:0] LOW_THRESH_DEF = 16'h0200;

    // Digit-wise BCD add; a carry out of the top digit clamps to 9999.
    function automatic logic [BCD_W-1:0] bcd_add_sat(input logic [BCD_W-1:0] a,
                                                     input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        logic [DIG_W:0]   s;
        logic             c;
        r = '0;
        c = 1'b0;
        for (int i = 0; i < int'(N_DIG); i++) begin
            s = (DIG_W+1)'(a[i*DIG_W +: DIG_W]) + (DIG_W+1)'(b[i*DIG_W +: DIG_W])
              + (DIG_W+1)'(c);
            if (s > (DIG_W+1)'(9)) begin
                s = s - (DIG_W+1)'(10);
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            r[i*DIG_W +: DIG_W] = s[DIG_W-1:0];
        end
        if (c) begin
            r = BCD_MAX;
        end
        return r;
    endfunction

    // Digit-wise BCD decrement by one; caller must not pass 0000.
    function automatic logic [BCD_W-1:0] bcd_dec(input logic [BCD_W-1:0] a);
        logic [BCD_W-1:0] r;
        logic [DIG_W-1:0] d;
        logic             borrow;
        r      = a;
        borrow = 1'b1;
        for (int i = 0; i < int'(N_DIG); i++) begin
            d = a[i*DIG_W +: DIG_W];
            if (borrow) begin
                if (d == DIG_W'(0)) begin
                    d = DIG_W'(9);
                end else begin
                    d      = d - DIG_W'(1);
                    borrow = 1'b0;
                end
            end
            r[i*DIG_W +: DIG_W] = d;
        end
        return r;
    endfunction

endpackage

// File: rtl/meter_tick_gen.sv
// Half-second divider producing the 1 s tick and, with METER_BLINK_EN, the flash phases.
module meter_tick_gen #(
    parameter int unsigned CLK_HZ = 100000000
) (
    input  logic clk,
    input  logic clr_n,
    input  logic hold,
`ifdef METER_BLINK_EN
    output logic half_phase,
    output logic sec_phase,
`endif
    output logic tick_c
);

    localparam int unsigned HALF  = CLK_HZ / 2;
    localparam int unsigned CNT_W = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic             half_phase_q;
    logic             wrap_c;
    logic             half_tick_c;

    assign wrap_c      = (cnt_q == CNT_W'(HALF - 1));
    assign half_tick_c = wrap_c && !hold;
    // half_phase doubles as the divide-by-two that turns half ticks into seconds
    assign tick_c      = half_tick_c && half_phase_q;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_q        <= '0;
            half_phase_q <= 1'b0;
        end else if (hold) begin
            cnt_q        <= '0;
            half_phase_q <= 1'b0;
        end else if (half_tick_c) begin
            cnt_q        <= '0;
            half_phase_q <= ~half_phase_q;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

`ifdef METER_BLINK_EN
    logic sec_phase_q;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sec_phase_q <= 1'b0;
        end else if (hold) begin
            sec_phase_q <= 1'b0;
        end else if (tick_c) begin
            sec_phase_q <= ~sec_phase_q;
        end
    end

    assign half_phase = half_phase_q;
    assign sec_phase  = sec_phase_q;
`endif

endmodule

// File: rtl/meter_time_core.sv
// Parking-meter remaining-time register: presets, coin adds, 1 s countdown and flash control.
// Define METER_BLINK_EN to enable the blank flashing; otherwise blank is tied low.
module meter_time_core
    import meter_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100000000,
    parameter logic [15:0] LOW_THRESH = LOW_THRESH_DEF
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       add50,
    input  logic       add150,
    input  logic       add200,
    input  logic       add500,
    input  logic       pre15,
    input  logic       pre185,
    output logic [3:0] bcd3,
    output logic [3:0] bcd2,
    output logic [3:0] bcd1,
    output logic [3:0] bcd0,
    output logic       blank,
    output logic       zero,
    output logic       low
);

    logic [BCD_W-1:0] t_q;
    logic [BCD_W-1:0] t_d;
    logic             pend_q;
    logic             pend_d;
    logic             preset_c;
    logic             add_c;
    logic [BCD_W-1:0] add_amt_c;
    logic             tick_c;

`ifdef METER_BLINK_EN
    logic half_phase;
    logic sec_phase;
`endif

    assign preset_c = pre15 || pre185;

    meter_tick_gen #(
        .CLK_HZ(CLK_HZ)
    ) u_tick_gen (
        .clk       (clk),
        .clr_n     (clr_n),
        .hold      (preset_c),
`ifdef METER_BLINK_EN
        .half_phase(half_phase),
        .sec_phase (sec_phase),
`endif
        .tick_c    (tick_c)
    );

    // One coin per cycle; larger coins win, the rest are dropped.
    always_comb begin
        add_c     = 1'b0;
        add_amt_c = '0;
        if (add500) begin
            add_c     = 1'b1;
            add_amt_c = ADD500;
        end else if (add200) begin
            add_c     = 1'b1;
            add_amt_c = ADD200;
        end else if (add150) begin
            add_c     = 1'b1;
            add_amt_c = ADD150;
        end else if (add50) begin
            add_c     = 1'b1;
            add_amt_c = ADD50;
        end
    end

    // A tick that collides with an add is parked in pend so the second is not lost.
    always_comb begin
        t_d    = t_q;
        pend_d = pend_q;
        if (preset_c) begin
            t_d    = pre15 ? PRE15 : PRE185;
            pend_d = 1'b0;
        end else if (add_c) begin
            t_d = bcd_add_sat(t_q, add_amt_c);
            if (tick_c) begin
                pend_d = 1'b1;
            end
        end else if (tick_c || pend_q) begin
            if (t_q != '0) begin
                t_d = bcd_dec(t_q);
            end
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            t_q    <= '0;
            pend_q <= 1'b0;
        end else begin
            t_q    <= t_d;
            pend_q <= pend_d;
        end
    end

    assign bcd3 = t_q[15:12];
    assign bcd2 = t_q[11:8];
    assign bcd1 = t_q[7:4];
    assign bcd0 = t_q[3:0];

    // Packed BCD orders the same as binary, so a plain compare works.
    assign zero = (t_q == '0);
    assign low  = !zero && (t_q < LOW_THRESH);

`ifdef METER_BLINK_EN
    assign blank = zero ? half_phase : (low ? sec_phase : 1'b0);
`else
    assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_meter_time_core.sv
// Directed bench for meter_time_core at CLK_HZ=8 (one tick every 8 cycles).
module tb_meter_time_core;

    localparam logic [5:0] I_NONE = 6'b000000;
    localparam logic [5:0] I_P15  = 6'b100000;
    localparam logic [5:0] I_P185 = 6'b010000;
    localparam logic [5:0] I_A500 = 6'b001000;
    localparam logic [5:0] I_A200 = 6'b000100;
    localparam logic [5:0] I_A150 = 6'b000010;
    localparam logic [5:0] I_A50  = 6'b000001;

`ifdef METER_BLINK_EN
    localparam logic BLINK = 1'b1;
`else
    localparam logic BLINK = 1'b0;
`endif

    typedef struct {
        logic [5:0]  in;
        int          w;
        logic [15:0] bcd;
        logic        zero;
        logic        low;
        logic        blank;
    } vec_t;

    logic       clk;
    logic       clr_n;
    logic       add50, add150, add200, add500, pre15, pre185;
    logic [3:0] bcd3, bcd2, bcd1, bcd0;
    logic       blank, zero, low;

    int errors;
    int checks;
    vec_t tbl[18];

    meter_time_core #(
        .CLK_HZ    (8),
        .LOW_THRESH(16'h0200)
    ) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .add50 (add50),
        .add150(add150),
        .add200(add200),
        .add500(add500),
        .pre15 (pre15),
        .pre185(pre185),
        .bcd3  (bcd3),
        .bcd2  (bcd2),
        .bcd1  (bcd1),
        .bcd0  (bcd0),
        .blank (blank),
        .zero  (zero),
        .low   (low)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_bcd(input string name, input logic [15:0] exp);
        chk(name, 32'({bcd3, bcd2, bcd1, bcd0}), 32'(exp));
    endtask

    // Drive one input set for exactly one rising edge, then return at the next falling edge.
    task automatic pulse(input logic [5:0] v);
        {pre15, pre185, add500, add200, add150, add50} = v;
        @(negedge clk);
        {pre15, pre185, add500, add200, add150, add50} = I_NONE;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a falling edge; releases reset at the next falling edge.
    task automatic do_reset();
        clr_n = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        clr_n  = 1'b0;
        {pre15, pre185, add500, add200, add150, add50} = I_NONE;

        tbl[0]  = '{I_P15,          1,   16'h0015, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{I_A150,         1,   16'h0165, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{I_A200,         1,   16'h0365, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{I_NONE,         5,   16'h0365, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{I_NONE,         1,   16'h0364, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{I_P185,         1,   16'h0185, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{I_A500 | I_A50, 1,   16'h0685, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{I_A150 | I_A50, 1,   16'h0835, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{I_A200 | I_A150,1,   16'h1035, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{I_NONE,         4,   16'h1035, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{I_A50,          1,   16'h1085, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{I_NONE,         1,   16'h1084, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{I_NONE,         7,   16'h1083, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{I_P15 | I_P185, 1,   16'h0015, 1'b0, 1'b1, 1'b0};
        tbl[14] = '{I_NONE,         7,   16'h0015, 1'b0, 1'b1, 1'b0};
        tbl[15] = '{I_NONE,         1,   16'h0014, 1'b0, 1'b1, BLINK};
        tbl[16] = '{I_NONE,         112, 16'h0000, 1'b1, 1'b0, 1'b0};
        tbl[17] = '{I_NONE,         16,  16'h0000, 1'b1, 1'b0, 1'b0};

        // Reset state
        idle(2);
        chk_bcd("reset_bcd", 16'h0000);
        chk("reset_zero", 32'(zero), 32'd1);
        chk("reset_low", 32'(low), 32'd0);
        chk("reset_blank", 32'(blank), 32'd0);

        // Single add50 after reset, first decrement 8 edges after release
        clr_n = 1'b1;
        pulse(I_A50);
        chk_bcd("add50_bcd", 16'h0050);
        chk("add50_zero", 32'(zero), 32'd0);
        chk("add50_low", 32'(low), 32'd1);
        idle(6);
        chk_bcd("add50_pre_tick", 16'h0050);
        idle(1);
        chk_bcd("add50_tick", 16'h0049);

        // pre185 held 20 cycles, then released
        pre185 = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1 || i == 10 || i == 20) chk_bcd("pre185_hold", 16'h0185);
        end
        pre185 = 1'b0;
        idle(7);
        chk_bcd("pre185_rel7", 16'h0185);
        idle(1);
        chk_bcd("pre185_rel8", 16'h0184);
        idle(7);
        chk_bcd("pre185_rel15", 16'h0184);
        idle(1);
        chk_bcd("pre185_rel16", 16'h0183);

        // Table-driven vectors; row 0 resets the divider phase via the preset
        for (int i = 0; i < 18; i++) begin
            pulse(tbl[i].in);
            idle(tbl[i].w - 1);
            chk($sformatf("vec%0d_bcd", i), 32'({bcd3, bcd2, bcd1, bcd0}), 32'(tbl[i].bcd));
            chk($sformatf("vec%0d_zero", i), 32'(zero), 32'(tbl[i].zero));
            chk($sformatf("vec%0d_low", i), 32'(low), 32'(tbl[i].low));
            chk($sformatf("vec%0d_blank", i), 32'(blank), 32'(tbl[i].blank));
        end

        // Saturation: reach 9900 with back-to-back adds, then overflow
        do_reset();
        for (int i = 0; i < 19; i++) pulse(I_A500);
        pulse(I_A200);
        pulse(I_A200);
        chk_bcd("sat_9900", 16'h9900);
        pulse(I_A500);
        chk_bcd("sat_add500", 16'h9999);
        pulse(I_A50);
        chk_bcd("sat_add50", 16'h9999);
        pulse(I_NONE);
        chk_bcd("sat_single_dec", 16'h9998);

        // Simultaneous adds from zero, then add on a tick edge
        do_reset();
        pulse(I_A500 | I_A50);
        chk_bcd("dual_add", 16'h0500);
        idle(6);
        pulse(I_A50);
        chk_bcd("add_on_tick_sum", 16'h0550);
        idle(1);
        chk_bcd("add_on_tick_dec", 16'h0549);

        // Flash at zero: half-second phase
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk($sformatf("blank_zero_k%0d", k), 32'(blank), 32'(BLINK & logic'((k / 4) % 2)));
        end
        chk("zero_hold", 32'(zero), 32'd1);

        // Flash at 0150: one-second phase
        do_reset();
        pulse(I_A150);
        for (int k = 2; k <= 20; k++) begin
            @(negedge clk);
            chk($sformatf("blank_low_k%0d", k), 32'(blank), 32'(BLINK & logic'((k / 8) % 2)));
        end

        // Threshold boundary: 0200 not low, 0199 low
        do_reset();
        pulse(I_A200);
        chk("low_0200", 32'(low), 32'd0);
        for (int k = 2; k <= 7; k++) begin
            @(negedge clk);
            chk($sformatf("blank_0200_k%0d", k), 32'(blank), 32'd0);
        end
        idle(1);
        chk_bcd("bcd_0199", 16'h0199);
        chk("low_0199", 32'(low), 32'd1);

        // Reset mid-count at 0123 with a parked tick
        pulse(I_P15);
        pulse(I_A50);
        pulse(I_A50);
        idle(334);
        chk_bcd("mid_0073", 16'h0073);
        idle(7);
        pulse(I_A50);
        chk_bcd("mid_0123", 16'h0123);
        clr_n = 1'b0;
        #1;
        chk_bcd("mid_reset_bcd", 16'h0000);
        chk("mid_reset_zero", 32'(zero), 32'd1);
        @(negedge clk);
        clr_n = 1'b1;
        pulse(I_A50);
        chk_bcd("post_reset_add", 16'h0050);
        idle(1);
        chk_bcd("post_reset_no_pend", 16'h0050);
        idle(5);
        chk_bcd("post_reset_p7", 16'h0050);
        idle(1);
        chk_bcd("post_reset_p8", 16'h0049);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
